// File: rtl/uart_receiver_if.sv
// Receive-side signal bundle: serial line and tick in, recovered byte and status out.
interface uart_receiver_if #(
    parameter int DATA_BITS = 8
);
    logic                 s_tick;
    logic                 rx;
    logic [DATA_BITS-1:0] dout;
    logic                 rx_done_tick;
    logic                 frame_err;

    modport master (
        output s_tick,
        output rx,
        input  dout,
        input  rx_done_tick,
        input  frame_err
    );

    modport slave (
        input  s_tick,
        input  rx,
        output dout,
        output rx_done_tick,
        output frame_err
    );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receive engine using 16x oversampling; mid-bit sampling, glitch rejection
// on the start bit and stop-bit framing error reporting.
module uart_receiver #(
    parameter int DATA_BITS = 8,
    parameter int SB_TICK   = 16
) (
    input  logic           clk,
    input  logic           reset,
    uart_receiver_if.slave bus
);
    localparam int S_W = (SB_TICK > 16) ? 5 : 4;
    localparam int N_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [S_W-1:0] S_MID  = S_W'(7);
    localparam logic [S_W-1:0] S_BIT  = S_W'(15);
    localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(DATA_BITS - 1);

    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [1:0]           r_state;
    logic [S_W-1:0]       r_s;
    logic [N_W-1:0]       r_n;
    logic [DATA_BITS-1:0] r_b;
    logic [DATA_BITS-1:0] r_dout;
    logic                 r_rx_done;
    logic                 r_frame_err;
    logic                 w_rx_s;

    assign w_rx_s = r_rx_s;

    // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= bus.rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_s         <= '0;
            r_n         <= '0;
            r_b         <= '0;
            r_dout      <= '0;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= ST_START;
                        r_s     <= '0;
                    end
                end
                ST_START: begin
                    if (bus.s_tick) begin
                        if (r_s == S_MID) begin
                            if (!w_rx_s) begin
                                r_state <= ST_DATA;
                                r_s     <= '0;
                                r_n     <= '0;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (bus.s_tick) begin
                        if (r_s == S_BIT) begin
                            r_s <= '0;
                            r_b <= {w_rx_s, r_b[DATA_BITS-1:1]};
                            if (r_n == N_LAST) begin
                                r_state <= ST_STOP;
                            end else begin
                                r_n <= r_n + 1'b1;
                            end
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (bus.s_tick) begin
                        if (r_s == S_STOP) begin
                            r_state     <= ST_IDLE;
                            r_dout      <= r_b;
                            r_frame_err <= ~w_rx_s;
                            r_rx_done   <= 1'b1;
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.dout         = r_dout;
    assign bus.rx_done_tick = r_rx_done;
    assign bus.frame_err    = r_frame_err;
endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: a tick-counting serial transmitter model feeds
// a scoreboard queue that a monitor drains on every completion pulse.
module tb_uart_receiver;
    localparam int DATA_BITS = 8;
    localparam int SB_TICK   = 16;

    logic clk;
    logic reset;

    uart_receiver_if #(.DATA_BITS(DATA_BITS)) bus ();

    uart_receiver #(
        .DATA_BITS (DATA_BITS),
        .SB_TICK   (SB_TICK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned pulses   = 0;
    int unsigned sent     = 0;
    int unsigned tick_cnt = 0;
    int unsigned fall_tick = 0;
    int          gap_min  = 4;
    int          gap_max  = 4;
    bit          meas_en  = 0;
    logic [8:0]  exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tick generator; a gap of 1 holds s_tick high continuously.
    initial begin
        int g;
        bus.s_tick = 1'b0;
        repeat (3) @(negedge clk);
        forever begin
            g = $urandom_range(gap_max, gap_min);
            bus.s_tick = 1'b1;
            tick_cnt++;
            @(negedge clk);
            if (g > 1) begin
                bus.s_tick = 1'b0;
                repeat (g - 1) @(negedge clk);
            end
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!bus.s_tick) @(posedge clk);
        end
    endtask

    // Must be called right after a tick; abort_bit >= 0 resets the DUT midway through that data bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_val, input int abort_bit);
        if (abort_bit < 0) begin
            exp_q.push_back({~stop_val, d});
            sent++;
        end
        @(negedge clk);
        bus.rx = 1'b0;
        fall_tick = tick_cnt;
        wait_ticks(16);
        for (int i = 0; i < DATA_BITS; i++) begin
            @(negedge clk);
            bus.rx = d[i];
            if (abort_bit == i) begin
                wait_ticks(8);
                @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                check("reset_dout", bus.dout, 0);
                check("reset_ferr", bus.frame_err, 0);
                check("reset_done", bus.rx_done_tick, 0);
                bus.rx = 1'b1;
                repeat (2) @(negedge clk);
                reset = 1'b0;
                return;
            end
            wait_ticks(16);
        end
        @(negedge clk);
        bus.rx = stop_val;
        if (stop_val) begin
            wait_ticks(SB_TICK);
        end else begin
            wait_ticks(12);
            @(negedge clk);
            bus.rx = 1'b1;
            wait_ticks(4);
        end
        @(negedge clk);
        bus.rx = 1'b1;
    endtask

    // Monitor: pops the scoreboard on each completion pulse.
    initial begin
        logic       prev_done;
        logic [8:0] e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_done = 1'b0;
            end else begin
                if (bus.rx_done_tick) begin
                    pulses++;
                    check("single_cycle_pulse", prev_done, 0);
                    check("frame_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("dout", bus.dout, e[7:0]);
                        check("frame_err", bus.frame_err, e[8]);
                    end
                    if (meas_en) begin
                        meas_en = 0;
                        check("latency_152_ticks",
                              (tick_cnt - fall_tick >= 151) && (tick_cnt - fall_tick <= 153), 1);
                    end
                end
                prev_done = bus.rx_done_tick;
            end
        end
    end

    initial begin
        repeat (98000) @(posedge clk);
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        bus.rx = 1'b1;
        reset  = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_dout", bus.dout, 0);
        check("rst_ferr", bus.frame_err, 0);
        check("rst_done", bus.rx_done_tick, 0);
        reset = 1'b0;
        wait_ticks(4);

        // Start-bit glitch: shorter than half a bit, must be rejected.
        @(negedge clk);
        bus.rx = 1'b0;
        wait_ticks(5);
        @(negedge clk);
        bus.rx = 1'b1;
        wait_ticks(24);
        check("glitch_no_pulse", pulses, 0);
        check("glitch_dout_held", bus.dout, 8'h00);

        meas_en = 1;
        send_frame(8'hA5, 1'b1, -1);
        wait_ticks(8);

        send_frame(8'h3C, 1'b0, -1);
        wait_ticks(16);
        send_frame(8'h55, 1'b1, -1);
        wait_ticks(8);

        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        send_frame(8'h81, 1'b1, -1);
        wait_ticks(8);
        check("b2b_last_dout", bus.dout, 8'h81);

        send_frame(8'hF0, 1'b1, 4);
        wait_ticks(20);
        check("abort_no_pulse_dout", bus.dout, 8'h00);
        send_frame(8'h12, 1'b1, -1);
        wait_ticks(8);

        gap_min = 1;
        gap_max = 2;
        wait_ticks(2);
        for (int v = 0; v < 256; v++) begin
            send_frame(8'(v), 1'b1, -1);
        end

        budget = 2000;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("queue_drained", exp_q.size(), 0);
        check("pulse_count", pulses, sent);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
